i2c_target_regs: RTL and testbench

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs.sv | 180 ++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS 8-bit registers with an auto-incrementing pointer.
// SCL/SDA are synchronized and glitch-filtered; SDA is only ever pulled low or released.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i2c_scl_i,
    output logic                        i2c_scl_o,
    output logic                        i2c_scl_t,
    input  logic                        i2c_sda_i,
    output logic                        i2c_sda_o,
    output logic                        i2c_sda_t,
    input  logic [$clog2(NUM_REGS)-1:0] reg_raddr,
    output logic [7:0]                  reg_rdata,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic [7:0]                  wr_data,
    output logic                        busy
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through sync, filter and edge detect.
    logic [1:0]    r_sync_p0, r_sync_p1, r_filt, r_filt_d;
    logic [CW-1:0] r_cnt [2];

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [AW-1:0] r_ptr;
    logic          r_first, r_busy, r_sda_t;
    logic          r_wr_strobe;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [7:0]    r_regs [NUM_REGS];

    logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_match;
    logic [7:0]    w_rd_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0 <= 2'b11;
            r_sync_p1 <= 2'b11;
            r_filt    <= 2'b11;
            r_filt_d  <= 2'b11;
            r_cnt[0]  <= '0;
            r_cnt[1]  <= '0;
        end else begin
            r_sync_p0 <= {i2c_sda_i, i2c_scl_i};
            r_sync_p1 <= r_sync_p0;
            r_filt_d  <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync_p1[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_filt[i] <= r_sync_p1[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_scl_rise = r_filt[0] & ~r_filt_d[0];
    assign w_scl_fall = ~r_filt[0] & r_filt_d[0];
    assign w_start    = r_filt[0] & r_filt_d[0] & r_filt_d[1] & ~r_filt[1];
    assign w_stop     = r_filt[0] & r_filt_d[0] & ~r_filt_d[1] & r_filt[1];
    assign w_rd_byte  = r_regs[r_ptr];

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_match = 1'b0;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_fall && r_bitcnt == 4'd8) begin
                        if (r_shift[7:1] == DEV_ADDR) begin
                            w_addr_match = 1'b1;
                            w_state_nxt  = S_ADDR_ACK;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_ADDR_ACK: if (w_scl_fall) w_state_nxt = r_shift[0] ? S_RD_BYTE : S_WR_BYTE;
                S_WR_BYTE:  if (w_scl_fall && r_bitcnt == 4'd8) w_state_nxt = S_WR_ACK;
                S_WR_ACK:   if (w_scl_fall) w_state_nxt = S_WR_BYTE;
                S_RD_BYTE:  if (w_scl_fall && r_bitcnt == 4'd7) w_state_nxt = S_RD_ACK;
                S_RD_ACK: begin
                    // Master NACK ends the read at once; an ACK continues on the falling edge.
                    if (w_scl_rise && r_filt[1]) w_state_nxt = S_IDLE;
                    else if (w_scl_fall) w_state_nxt = S_RD_BYTE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_sda_t     <= 1'b1;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_strobe <= 1'b0;
            // Array update lags the strobe by one cycle so readers see old data during it.
            if (r_wr_strobe) r_regs[r_wr_addr] <= r_wr_data;

            if (w_state_nxt == S_IDLE) r_busy <= 1'b0;
            else if (w_addr_match)     r_busy <= 1'b1;

            if (w_start || w_stop || w_state_nxt != r_state) begin
                r_bitcnt <= '0;
            end else if ((r_state == S_ADDR || r_state == S_WR_BYTE) && w_scl_rise && r_bitcnt != 4'd8) begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_shift  <= {r_shift[6:0], r_filt[1]};
            end else if (r_state == S_RD_BYTE && w_scl_fall) begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_shift  <= {r_shift[6:0], 1'b0};
            end

            if (r_state == S_ADDR_ACK && w_state_nxt == S_WR_BYTE) r_first <= 1'b1;
            if (r_state == S_WR_BYTE && w_state_nxt == S_WR_ACK) begin
                if (r_first) begin
                    r_ptr   <= r_shift[AW-1:0];
                    r_first <= 1'b0;
                end else begin
                    r_wr_strobe <= 1'b1;
                    r_wr_addr   <= r_ptr;
                    r_wr_data   <= r_shift;
                    r_ptr       <= r_ptr + AW'(1);
                end
            end
            if (r_state == S_RD_BYTE && w_state_nxt == S_RD_ACK) r_ptr <= r_ptr + AW'(1);
            if (r_state != S_RD_BYTE && w_state_nxt == S_RD_BYTE) r_shift <= w_rd_byte;

            case (w_state_nxt)
                S_ADDR_ACK, S_WR_ACK: r_sda_t <= 1'b0;
                S_RD_BYTE: begin
                    if (r_state != S_RD_BYTE) r_sda_t <= w_rd_byte[7];
                    else if (w_scl_fall)      r_sda_t <= r_shift[6];
                end
                default: r_sda_t <= 1'b1;
            endcase
        end
    end

    assign i2c_scl_o = 1'b0;
    assign i2c_scl_t = 1'b1;
    assign i2c_sda_o = 1'b0;
    assign i2c_sda_t = r_sda_t;
    assign reg_rdata = r_regs[reg_raddr];
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: an open-drain I2C master model driving directed,
// table-driven and randomized transfers against a simple register-file model.
module tb_i2c_target_regs;
    localparam int FLEN = 4;
    localparam int Q    = 10;

    logic       clk;
    logic       rst;
    logic       m_scl, m_sda;
    logic       scl_line, sda_line;
    logic       scl_o, scl_t, sda_o, sda_t;
    logic [3:0] reg_raddr;
    logic [7:0] reg_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign scl_line = m_scl & (scl_t ? 1'b1 : scl_o);
    assign sda_line = m_sda & (sda_t ? 1'b1 : sda_o);

    i2c_target_regs #(.DEV_ADDR(7'h50), .NUM_REGS(16), .FILTER_LEN(FLEN)) dut (
        .clk(clk), .rst(rst),
        .i2c_scl_i(scl_line), .i2c_scl_o(scl_o), .i2c_scl_t(scl_t),
        .i2c_sda_i(sda_line), .i2c_sda_o(sda_o), .i2c_sda_t(sda_t),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       hit;
        logic [7:0] rd_in;
        logic [7:0] rd_next;
    } ev_t;
    ev_t ev_q[$];
    ev_t mon_e;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            mon_e.addr  = wr_addr;
            mon_e.data  = wr_data;
            mon_e.hit   = (reg_raddr == wr_addr);
            mon_e.rd_in = reg_rdata;
            @(negedge clk);
            mon_e.rd_next = reg_rdata;
            ev_q.push_back(mon_e);
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_strobe(input string nm, input int ea, input int ed, input int eold);
        ev_t e;
        if (ev_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got no wr_strobe, required addr %0d data %0h", nm, ea, ed);
        end else begin
            e = ev_q.pop_front();
            chk({nm, "_addr"}, 32'(e.addr), 32'(ea));
            chk({nm, "_data"}, 32'(e.data), 32'(ed));
            if (e.hit) begin
                chk({nm, "_rd_old"}, 32'(e.rd_in), 32'(eold));
                chk({nm, "_rd_new"}, 32'(e.rd_next), 32'(ed));
            end
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q();
        r = sda_line; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic wb(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic rb(output logic [7:0] d, input logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(~ack, r);
    endtask

    typedef struct {
        logic [7:0] ptr_byte;
        logic [7:0] data;
        logic [3:0] exp_addr;
        logic [7:0] exp_old;
    } vec_t;
    vec_t tbl [5];

    logic [7:0] mregs [16];
    int         mptr;
    int         kind, nbytes;
    logic       ack;
    logic [7:0] d, p;

    initial begin
        tbl[0] = '{8'h07, 8'h96, 4'd7,  8'h00};
        tbl[1] = '{8'h19, 8'h3C, 4'd9,  8'h00};
        tbl[2] = '{8'h02, 8'hFF, 4'd2,  8'h00};
        tbl[3] = '{8'hFE, 8'h01, 4'd14, 8'h00};
        tbl[4] = '{8'h24, 8'h7E, 4'd4,  8'hC3};

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; reg_raddr = 4'd0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sda_t", 32'(sda_t), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobe", 32'(wr_strobe), 0);
        chk("rst_rdata0", 32'(reg_rdata), 0);
        chk("scl_t_const", 32'(scl_t), 1);
        chk("scl_o_const", 32'(scl_o), 0);

        // Plain write of two data bytes starting at register 3.
        reg_raddr = 4'd4;
        i2c_start();
        wb(8'hA0, ack); chk("w1_addr_ack", 32'(ack), 1);
        chk("w1_busy", 32'(busy), 1);
        wb(8'h03, ack); chk("w1_ptr_ack", 32'(ack), 1);
        wb(8'h5A, ack); chk("w1_d0_ack", 32'(ack), 1);
        wb(8'hC3, ack); chk("w1_d1_ack", 32'(ack), 1);
        i2c_stop();
        chk("w1_busy_after_stop", 32'(busy), 0);
        chk_strobe("w1_s0", 3, 8'h5A, 0);
        chk_strobe("w1_s1", 4, 8'hC3, 0);
        chk("w1_rdata4", 32'(reg_rdata), 32'h C3);

        // Pointer set, repeated START, read two bytes.
        i2c_start();
        wb(8'hA0, ack); chk("r1_addr_ack", 32'(ack), 1);
        wb(8'h03, ack); chk("r1_ptr_ack", 32'(ack), 1);
        i2c_start();
        wb(8'hA1, ack); chk("r1_raddr_ack", 32'(ack), 1);
        rb(d, 1'b1); chk("r1_byte0", 32'(d), 32'h5A);
        rb(d, 1'b0); chk("r1_byte1", 32'(d), 32'hC3);
        chk("r1_busy_after_nack", 32'(busy), 0);
        chk("r1_sda_released", 32'(sda_t), 1);
        i2c_stop();
        chk("r1_no_strobe", 32'(ev_q.size()), 0);

        // Foreign address is not acknowledged.
        i2c_start();
        wb(8'hA2, ack); chk("na_ack", 32'(ack), 0);
        chk("na_busy", 32'(busy), 0);
        i2c_stop();
        chk("na_no_strobe", 32'(ev_q.size()), 0);

        // Pointer wrap from 15 to 0.
        reg_raddr = 4'd0;
        i2c_start();
        wb(8'hA0, ack); wb(8'h0F, ack);
        wb(8'h11, ack); chk("wrap_d0_ack", 32'(ack), 1);
        wb(8'h22, ack); chk("wrap_d1_ack", 32'(ack), 1);
        i2c_stop();
        chk_strobe("wrap_s0", 15, 8'h11, 0);
        chk_strobe("wrap_s1", 0, 8'h22, 0);
        reg_raddr = 4'd15; @(negedge clk);
        chk("wrap_rdata15", 32'(reg_rdata), 32'h11);

        // Short SDA glitch with SCL high must not count as START.
        @(negedge clk); m_sda = 1'b0;
        repeat (FLEN - 1) @(negedge clk);
        m_sda = 1'b1;
        wait_q();
        m_scl = 1'b0; wait_q();
        wb(8'hA0, ack); chk("glitch_no_start", 32'(ack), 0);
        chk("glitch_busy", 32'(busy), 0);
        i2c_stop();

        for (int i = 0; i < 5; i++) begin
            reg_raddr = tbl[i].exp_addr;
            i2c_start();
            wb(8'hA0, ack); chk($sformatf("tbl%0d_addr_ack", i), 32'(ack), 1);
            wb(tbl[i].ptr_byte, ack); chk($sformatf("tbl%0d_ptr_ack", i), 32'(ack), 1);
            wb(tbl[i].data, ack); chk($sformatf("tbl%0d_data_ack", i), 32'(ack), 1);
            i2c_stop();
            chk_strobe($sformatf("tbl%0d_s", i), 32'(tbl[i].exp_addr), 32'(tbl[i].data), 32'(tbl[i].exp_old));
            chk($sformatf("tbl%0d_rdata", i), 32'(reg_rdata), 32'(tbl[i].data));
        end

        // Reset while the target drives a zero bit of a read.
        i2c_start();
        wb(8'hA0, ack); wb(8'h05, ack);
        i2c_stop();
        i2c_start();
        wb(8'hA1, ack); chk("rr_addr_ack", 32'(ack), 1);
        chk("rr_driving_low", 32'(sda_t), 0);
        rst = 1'b1; @(negedge clk);
        rst = 1'b0; @(negedge clk);
        chk("rr_sda_released", 32'(sda_t), 1);
        chk("rr_busy", 32'(busy), 0);
        for (int i = 0; i < 16; i++) begin
            reg_raddr = 4'(i); @(negedge clk);
            chk($sformatf("rr_reg%0d_zero", i), 32'(reg_rdata), 0);
        end
        i2c_stop();

        // Randomized transfers against the register-file model.
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mptr = 0;
        for (int t = 0; t < 10; t++) begin
            kind      = $urandom_range(0, 2);
            nbytes    = $urandom_range(1, 3);
            reg_raddr = 4'($urandom_range(0, 15));
            if (kind == 0) begin
                p = 8'($urandom);
                i2c_start();
                wb(8'hA0, ack); chk($sformatf("rnd%0d_addr_ack", t), 32'(ack), 1);
                wb(p, ack);     chk($sformatf("rnd%0d_ptr_ack", t), 32'(ack), 1);
                mptr = p % 16;
                for (int k = 0; k < nbytes; k++) begin
                    d = 8'($urandom);
                    wb(d, ack); chk($sformatf("rnd%0d_d%0d_ack", t, k), 32'(ack), 1);
                    chk_strobe($sformatf("rnd%0d_s%0d", t, k), mptr, 32'(d), 32'(mregs[mptr]));
                    mregs[mptr] = d;
                    mptr = (mptr + 1) % 16;
                end
                i2c_stop();
            end else begin
                if (kind == 2) begin
                    p = 8'($urandom);
                    i2c_start();
                    wb(8'hA0, ack); wb(p, ack);
                    mptr = p % 16;
                end
                i2c_start();
                wb(8'hA1, ack); chk($sformatf("rnd%0d_raddr_ack", t), 32'(ack), 1);
                for (int k = 0; k < nbytes; k++) begin
                    rb(d, k != nbytes - 1);
                    chk($sformatf("rnd%0d_rd%0d", t, k), 32'(d), 32'(mregs[mptr]));
                    mptr = (mptr + 1) % 16;
                end
                chk($sformatf("rnd%0d_busy_nack", t), 32'(busy), 0);
                i2c_stop();
            end
            chk($sformatf("rnd%0d_rdata", t), 32'(reg_rdata), 32'(mregs[reg_raddr]));
            chk($sformatf("rnd%0d_no_extra", t), 32'(ev_q.size()), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
